// File: rtl/bcd_key_entry_if.sv
// Board-side bundle for the decimal key-entry block: raw switch/key inputs
// plus the entered digits, converted value and status.
interface bcd_key_entry_if;
    logic [3:0] digit_in;
    logic       key_enter_n;
    logic       key_clear_n;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [1:0] digits;
    logic [6:0] value;
    logic       value_valid;
    logic       digit_err;

    // Board pins / stimulus side
    modport master (
        output digit_in,
        output key_enter_n,
        output key_clear_n,
        input  tens,
        input  ones,
        input  digits,
        input  value,
        input  value_valid,
        input  digit_err
    );

    // Entry block side
    modport slave (
        input  digit_in,
        input  key_enter_n,
        input  key_clear_n,
        output tens,
        output ones,
        output digits,
        output value,
        output value_valid,
        output digit_err
    );
endinterface

// File: rtl/bcd_key_entry.sv
// Two-digit decimal keypad entry: synchronizes and debounces KEY[1:0],
// collects tens/ones from SW[3:0] and converts them to a 7-bit binary value.
module bcd_key_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    bcd_key_entry_if.slave   bus
);

    localparam int unsigned CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned NKEY      = 2;
    localparam int unsigned KEY_ENTER = 0;
    localparam int unsigned KEY_CLEAR = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        CONV  = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic [3:0]      digit_meta;
    logic [3:0]      digit_sync;
    logic [NKEY-1:0] key_meta;
    logic [NKEY-1:0] key_sync;
    logic [NKEY-1:0] key_level;
    logic [NKEY-1:0] key_press;
    logic [CNT_W-1:0] key_cnt [NKEY];

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [1:0] digits_q, digits_d;
    logic [6:0] value_q, value_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    logic enter_ev_c;
    logic clear_ev_c;
    logic digit_ok_c;

    // Two-flop synchronizers; keys idle high so they reset released
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_meta <= '0;
            digit_sync <= '0;
            key_meta   <= '1;
            key_sync   <= '1;
        end else begin
            digit_meta <= bus.digit_in;
            digit_sync <= digit_meta;
            key_meta   <= {bus.key_clear_n, bus.key_enter_n};
            key_sync   <= key_meta;
        end
    end

    // Level debounce per key; a press pulse is registered on the 1->0 flip
    always_ff @(posedge clk) begin
        if (reset) begin
            key_level <= '1;
            key_press <= '0;
            for (int i = 0; i < NKEY; i++) begin
                key_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NKEY; i++) begin
                key_press[i] <= 1'b0;
                if (key_sync[i] == key_level[i]) begin
                    key_cnt[i] <= '0;
                end else if (key_cnt[i] == CNT_MAX) begin
                    key_level[i] <= key_sync[i];
                    key_cnt[i]   <= '0;
                    key_press[i] <= ~key_sync[i];
                end else begin
                    key_cnt[i] <= key_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign enter_ev_c = key_press[KEY_ENTER];
    assign clear_ev_c = key_press[KEY_CLEAR];
    assign digit_ok_c = (digit_sync <= 4'd9);

    // Entry state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            tens_q   <= '0;
            ones_q   <= '0;
            digits_q <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            digits_q <= digits_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Next-state: clear beats everything, CONV ignores enter presses
    always_comb begin
        state_d  = state_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        digits_d = digits_q;
        value_d  = value_q;
        valid_d  = 1'b0;
        err_d    = err_q;

        if (clear_ev_c) begin
            state_d  = EMPTY;
            tens_d   = '0;
            ones_d   = '0;
            digits_d = '0;
            value_d  = '0;
            err_d    = 1'b0;
        end else if (state_q == CONV) begin
            // tens*10 as tens*8 + tens*2; bounded to 99 so 7 bits suffice
            value_d = 7'({tens_q, 3'b000}) + 7'({tens_q, 1'b0}) + 7'(ones_q);
            valid_d = 1'b1;
            state_d = DONE;
        end else if (enter_ev_c) begin
            if (!digit_ok_c) begin
                err_d = 1'b1;
            end else begin
                err_d = 1'b0;
                case (state_q)
                    ONE: begin
                        tens_d   = ones_q;
                        ones_d   = digit_sync;
                        digits_d = 2'd2;
                        state_d  = CONV;
                    end
                    default: begin
                        tens_d   = '0;
                        ones_d   = digit_sync;
                        digits_d = 2'd1;
                        state_d  = ONE;
                    end
                endcase
            end
        end
    end

    assign bus.tens        = tens_q;
    assign bus.ones        = ones_q;
    assign bus.digits      = digits_q;
    assign bus.value       = value_q;
    assign bus.value_valid = valid_q;
    assign bus.digit_err   = err_q;

endmodule

// File: tb/tb_bcd_key_entry.sv
// Scoreboard bench for bcd_key_entry with a short debounce window.
module tb_bcd_key_entry;

    localparam int unsigned DEB = 4;
    // drive edge to value_valid sample: 2 sync + DEB debounce + event + CONV
    localparam int LAT = 8;

    typedef struct {
        int value;
        int tens;
        int ones;
        int due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   rise_cnt;
    logic prev_valid;
    logic [1:0] prev_digits;
    exp_t sb[$];

    bcd_key_entry_if bus();

    bcd_key_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_value(input int v, input int t, input int o, input bit timed);
        exp_t e;
        e.value = v;
        e.tens  = t;
        e.ones  = o;
        e.due   = timed ? cyc + LAT : 0;
        sb.push_back(e);
    endtask

    // Called at a negedge: clean press, hold, release, settle
    task automatic press(input bit en, input bit cl);
        bus.key_enter_n = ~en;
        bus.key_clear_n = ~cl;
        repeat (10) @(negedge clk);
        bus.key_enter_n = 1'b1;
        bus.key_clear_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic enter_digit(input logic [3:0] d);
        bus.digit_in = d;
        press(1'b1, 1'b0);
    endtask

    task automatic chk_outputs(input string tag, input int t, input int o, input int dg,
                               input int v, input int er);
        chk({tag, ".tens"},      int'(bus.tens),      t);
        chk({tag, ".ones"},      int'(bus.ones),      o);
        chk({tag, ".digits"},    int'(bus.digits),    dg);
        chk({tag, ".value"},     int'(bus.value),     v);
        chk({tag, ".digit_err"}, int'(bus.digit_err), er);
    endtask

    // Monitor: every value_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (bus.value_valid) begin
            chk("valid_single_cycle", int'(prev_valid), 0);
            if (sb.size() == 0) begin
                chk("unexpected_value_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("value", int'(bus.value), e.value);
                chk("conv_tens", int'(bus.tens), e.tens);
                chk("conv_ones", int'(bus.ones), e.ones);
                chk("conv_digits", int'(bus.digits), 2);
                if (e.due != 0) chk("valid_latency", cyc, e.due);
            end
        end
        if (prev_digits == 2'd0 && bus.digits == 2'd1) rise_cnt++;
        prev_valid  <= bus.value_valid;
        prev_digits <= bus.digits;
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        rise_cnt = 0;
        prev_valid = 1'b0;
        prev_digits = 2'd0;
        reset = 1'b1;
        bus.digit_in = 4'd0;
        bus.key_enter_n = 1'b1;
        bus.key_clear_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_outputs("reset", 0, 0, 0, 0, 0);
        chk("reset.value_valid", int'(bus.value_valid), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic 4 then 7, with exact strobe latency
        enter_digit(4'd4);
        chk_outputs("first_digit", 0, 4, 1, 0, 0);
        bus.digit_in = 4'd7;
        expect_value(47, 4, 7, 1'b1);
        press(1'b1, 1'b0);
        chk_outputs("basic_47", 4, 7, 2, 47, 0);

        // Invalid digit in DONE, then retry with 3
        enter_digit(4'd12);
        chk_outputs("bad_digit", 4, 7, 2, 47, 1);
        enter_digit(4'd3);
        chk_outputs("retry_digit", 0, 3, 1, 47, 0);

        press(1'b0, 1'b1);
        chk_outputs("clear", 0, 0, 0, 0, 0);

        // Bounce: 2-cycle toggles never qualify, then a long hold
        bus.digit_in = 4'd6;
        rise_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            bus.key_enter_n = 1'b0;
            repeat (2) @(negedge clk);
            bus.key_enter_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        chk("bounce_no_event", int'(bus.digits), 0);
        bus.key_enter_n = 1'b0;
        repeat (30) @(negedge clk);
        bus.key_enter_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("bounce_one_rise", rise_cnt, 1);
        chk_outputs("bounce", 0, 6, 1, 0, 0);
        press(1'b0, 1'b1);

        // Boundaries
        enter_digit(4'd0);
        bus.digit_in = 4'd0;
        expect_value(0, 0, 0, 1'b1);
        press(1'b1, 1'b0);
        enter_digit(4'd9);
        bus.digit_in = 4'd9;
        expect_value(99, 9, 9, 1'b1);
        press(1'b1, 1'b0);
        chk_outputs("value_99", 9, 9, 2, 7'h63, 0);
        enter_digit(4'd5);
        chk_outputs("restart_in_done", 0, 5, 1, 99, 0);

        // Clear and enter in the same cycle with one digit entered
        bus.digit_in = 4'd8;
        press(1'b1, 1'b1);
        chk_outputs("clear_wins", 0, 0, 0, 0, 0);

        // Reset landing on the CONV cycle
        enter_digit(4'd1);
        bus.digit_in = 4'd8;
        bus.key_enter_n = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.key_enter_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_outputs("reset_in_conv", 0, 0, 0, 0, 0);
        chk("reset_in_conv.valid", int'(bus.value_valid), 0);
        repeat (15) @(negedge clk);
        enter_digit(4'd2);
        chk_outputs("after_reset", 0, 2, 1, 0, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_key_entry.md
# bcd_key_entry

Keypad-style decimal entry block for the DE10-Lite: the input-side counterpart of the binary-to-decimal HEX display path. The operator sets a digit on SW[3:0] and presses KEY[0] to enter it, and KEY[1] clears the entry. After two valid digits, the block converts the two-digit decimal number (tens, ones) to a 7-bit binary value and pulses a valid strobe. It sits between the board's raw KEY/SW pins and downstream logic. Its tens/ones outputs feed the existing seven-segment path for echo.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz); legal range 2 to 2^20−1.
- clk  input  1  system clock (MAX10_CLK1_50).
- reset  input  1  synchronous, active-high reset.
- digit_in  input  4  digit from SW[3:0]; asynchronous, quasi-static.
- key_enter_n  input  1  KEY[0], active-low, raw and bouncing.
- key_clear_n  input  1  KEY[1], active-low, raw and bouncing.
- tens  output  4  entered tens digit (BCD).
- ones  output  4  entered ones digit (BCD).
- digits  output  2  number of digits currently entered: 0, 1 or 2.
- value  output  7  binary result, tens*10+ones, range 0–99.
- value_valid  output  1  one-cycle pulse when value is updated.
- digit_err  output  1  sticky flag; an enter press was made with digit_in > 9.

## Operation
- Synchronizers: digit_in, key_enter_n and key_clear_n each pass through a 2-flop synchronizer before any use.
- Debounce, one instance per key:
  - Debounced level resets to 1 (released); its counter resets to 0.
  - When the synchronized level differs from the debounced level, the counter increments. It clears on any cycle where the two levels match.
  - When the counter reaches DEBOUNCE_CYCLES−1 while the levels still differ, the debounced level flips and the counter clears.
  - A press event is a one-cycle pulse on the debounced 1→0 transition. Releases generate no event.
- State machine (states EMPTY, ONE, CONV, DONE). Reset state is EMPTY.
  - Clear event, in any state: go to EMPTY. tens, ones and value are set to 0, digits to 0, and digit_err to 0. value_valid is not pulsed.
  - Enter event with synchronized digit > 9: set digit_err to 1. State, tens and ones do not change.
  - EMPTY + valid enter: ones ← digit, tens ← 0, digits ← 1, go to ONE.
  - ONE + valid enter: tens ← ones, ones ← digit, digits ← 2, go to CONV.
  - CONV: unconditional, one cycle. value ← tens*8 + tens*2 + ones (7-bit; no overflow is possible because tens and ones are ≤ 9). value_valid is 1 in the following cycle. Go to DONE. Enter events arriving during CONV are ignored. Clear events are not ignored.
  - DONE + valid enter: begin a new entry. ones ← digit, tens ← 0, digits ← 1, go to ONE. value holds its previous result until the next conversion or a clear.
- A valid enter press clears digit_err (the bad press is "retried").
- Simultaneous clear and enter events in the same cycle: clear wins and the enter is discarded.
- The digit is sampled from the synchronized digit_in in the same cycle as the enter event.

## Timing
- Reset values: tens=0, ones=0, digits=0, value=0, value_valid=0, digit_err=0, state EMPTY, both debounced levels=1.
- Reset asserted mid-entry, mid-debounce or during CONV returns everything to the reset values on the next edge. No value_valid pulse is produced.
- Key latency: raw level held stable from cycle 0 produces the press event in cycle 2 + DEBOUNCE_CYCLES, within ±1.
- The enter event in cycle P updates tens, ones and digits at the end of cycle P.
- Second digit: state is CONV in cycle P+1. value and value_valid are updated together at the end of P+1, so value_valid is high exactly in cycle P+2.
- value_valid is never high for two consecutive cycles.
- Bounce shorter than DEBOUNCE_CYCLES cycles produces no event. Holding a key pressed produces exactly one event.

## Test plan
Run with DEBOUNCE_CYCLES=4.
- Basic entry: enter 4, then enter 7 (clean presses, released between them). Required: tens=4, ones=7, digits=2, value=47, a single value_valid pulse 2 cycles after the second press event.
- Bounce rejection: toggle key_enter_n 0/1 every 2 cycles for 20 cycles, then hold it at 0. Required: exactly one press event, and digits changes 0→1 only once.
- Invalid digit: digit_in=12 and enter. Required: digit_err=1 and digits unchanged. Then digit_in=3 and enter: required digit_err=0, ones=3.
- Boundaries: 0,0 → value=0 with value_valid. 9,9 → value=99 (7'h63). Entering 5 in DONE → digits=1, tens=0, ones=5, value still 99.
- Clear and enter in the same cycle with digits=1: required EMPTY, all outputs 0, no value_valid.
- Reset asserted in the CONV cycle: required no value_valid pulse, value=0, state EMPTY next cycle.
